// File: rtl/rob_commit_unit_pkg.sv
// Shared encodings for the ROB, dispatch and in-order commit logic.
// Instruction type codes, the "finished" state value and the commit FSM state type.
package rob_commit_unit_pkg;

  localparam logic [1:0] INS_TYPE_ALU    = 2'b00;
  localparam logic [1:0] INS_TYPE_STORE  = 2'b01;
  localparam logic [1:0] INS_TYPE_BRANCH = 2'b10;
  localparam logic [1:0] INS_TYPE_HALT   = 2'b11;

  localparam logic INS_STATE_FINISHED = 1'b1;

  typedef enum logic [1:0] {
    CS_RUN        = 2'd0,
    CS_STORE_WAIT = 2'd1,
    CS_HALTED     = 2'd2
  } commit_state_e;

endpackage

// File: rtl/rob_commit_unit_retire_counter.sv
// Wrapping up-counter of retired instructions, used for performance reporting.
module retire_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_inc,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement controller sitting on the ROB head: retires finished entries,
// drives the register-file commit port, handshakes stores with memory and freezes on HALT.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_ADDR_SIZE  = 5,
  parameter int DEST_ADDR_SIZE = 4,
  parameter int INS_TYPE_SIZE  = 2,
  parameter int INS_STATE_SIZE = 1,
  parameter logic [INS_STATE_SIZE-1:0] FINISHED_STATE = INS_STATE_SIZE'(INS_STATE_FINISHED),
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROB_ADDR_SIZE-1:0]  i_rob_head_id,
  input  logic [ROB_ADDR_SIZE-1:0]  i_rob_tail_id,
  input  logic                      i_rob_is_full,
  input  logic [INS_STATE_SIZE-1:0] i_rob_head_state,
  input  logic [DEST_ADDR_SIZE-1:0] i_rob_head_dest,
  input  logic [INS_TYPE_SIZE-1:0]  i_rob_head_type,
  input  logic                      i_commit_en,
  input  logic                      i_st_ack,
  output logic                      o_commit_head,
  output logic                      o_rf_commit_valid,
  output logic [DEST_ADDR_SIZE-1:0] o_rf_commit_addr,
  output logic [ROB_ADDR_SIZE-1:0]  o_rf_commit_rob_id,
  output logic                      o_st_req,
  output logic [ROB_ADDR_SIZE-1:0]  o_st_rob_id,
  output logic                      o_halted,
  output logic [COUNT_WIDTH-1:0]    o_retired_count
);

  commit_state_e r_state;
  commit_state_e w_next_state;

  logic [ROB_ADDR_SIZE-1:0]  r_st_rob_id;
  logic                      w_rob_empty;
  logic                      w_head_ready;
  logic                      w_latch_store;
  logic                      w_commit_head;
  logic                      w_rf_valid;
  logic [DEST_ADDR_SIZE-1:0] w_rf_addr;
  logic [ROB_ADDR_SIZE-1:0]  w_rf_rob_id;
  logic                      w_st_req;
  logic [ROB_ADDR_SIZE-1:0]  w_st_rob_id;
  logic                      w_halted;

  // A full ROB also has head == tail, so the full flag disambiguates it from empty.
  assign w_rob_empty  = (i_rob_head_id == i_rob_tail_id) && !i_rob_is_full;
  assign w_head_ready = !w_rob_empty && (i_rob_head_state == FINISHED_STATE) && i_commit_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CS_RUN;
      r_st_rob_id <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch_store) begin
        r_st_rob_id <= i_rob_head_id;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_latch_store = 1'b0;
    w_commit_head = 1'b0;
    w_rf_valid    = 1'b0;
    w_rf_addr     = '0;
    w_rf_rob_id   = '0;
    w_st_req      = 1'b0;
    w_st_rob_id   = r_st_rob_id;
    w_halted      = 1'b0;
    case (r_state)
      CS_RUN: begin
        if (w_head_ready) begin
          if (i_rob_head_type == INS_TYPE_SIZE'(INS_TYPE_ALU)) begin
            w_commit_head = 1'b1;
            w_rf_valid    = 1'b1;
            w_rf_addr     = i_rob_head_dest;
            w_rf_rob_id   = i_rob_head_id;
          end else if (i_rob_head_type == INS_TYPE_SIZE'(INS_TYPE_BRANCH)) begin
            w_commit_head = 1'b1;
          end else if (i_rob_head_type == INS_TYPE_SIZE'(INS_TYPE_STORE)) begin
            w_latch_store = 1'b1;
            w_next_state  = CS_STORE_WAIT;
          end else begin
            w_commit_head = 1'b1;
            w_next_state  = CS_HALTED;
          end
        end
      end
      // The memory write has already happened on ack, so downstream stalls cannot block it.
      CS_STORE_WAIT: begin
        w_st_req = 1'b1;
        if (i_st_ack) begin
          w_commit_head = 1'b1;
          w_next_state  = CS_RUN;
        end
      end
      CS_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = CS_RUN;
      end
    endcase
    if (reset) begin
      w_next_state  = CS_RUN;
      w_latch_store = 1'b0;
      w_commit_head = 1'b0;
      w_rf_valid    = 1'b0;
      w_rf_addr     = '0;
      w_rf_rob_id   = '0;
      w_st_req      = 1'b0;
      w_st_rob_id   = '0;
      w_halted      = 1'b0;
    end
  end

  assign o_commit_head      = w_commit_head;
  assign o_rf_commit_valid  = w_rf_valid;
  assign o_rf_commit_addr   = w_rf_addr;
  assign o_rf_commit_rob_id = w_rf_rob_id;
  assign o_st_req           = w_st_req;
  assign o_st_rob_id        = w_st_rob_id;
  assign o_halted           = w_halted;

  retire_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_retire_counter (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_commit_head),
    .o_count(o_retired_count)
  );

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed, table-driven bench for rob_commit_unit: one table row per clock cycle,
// followed by a hand-written back-to-back retirement run from a full ROB.
module tb_rob_commit_unit;

  typedef struct {
    logic       rst;
    logic [4:0] head;
    logic [4:0] tail;
    logic       full;
    logic       st;
    logic [3:0] dest;
    logic [1:0] typ;
    logic       en;
    logic       ack;
    logic       eCh;
    logic       eRv;
    logic [3:0] eRa;
    logic [4:0] eRid;
    logic       eSr;
    logic [4:0] eSid;
    logic       eHl;
    int         eCnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  robHeadId;
  logic [4:0]  robTailId;
  logic        robIsFull;
  logic [0:0]  robHeadState;
  logic [3:0]  robHeadDest;
  logic [1:0]  robHeadType;
  logic        commitEn;
  logic        stAck;
  logic        commitHead;
  logic        rfCommitValid;
  logic [3:0]  rfCommitAddr;
  logic [4:0]  rfCommitRobId;
  logic        stReq;
  logic [4:0]  stRobId;
  logic        halted;
  logic [31:0] retiredCount;

  int total;
  int bad;
  vec_t vecs[$];

  rob_commit_unit dut (
    .clk               (clk),
    .reset             (reset),
    .i_rob_head_id     (robHeadId),
    .i_rob_tail_id     (robTailId),
    .i_rob_is_full     (robIsFull),
    .i_rob_head_state  (robHeadState),
    .i_rob_head_dest   (robHeadDest),
    .i_rob_head_type   (robHeadType),
    .i_commit_en       (commitEn),
    .i_st_ack          (stAck),
    .o_commit_head     (commitHead),
    .o_rf_commit_valid (rfCommitValid),
    .o_rf_commit_addr  (rfCommitAddr),
    .o_rf_commit_rob_id(rfCommitRobId),
    .o_st_req          (stReq),
    .o_st_rob_id       (stRobId),
    .o_halted          (halted),
    .o_retired_count   (retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    robHeadId    = v.head;
    robTailId    = v.tail;
    robIsFull    = v.full;
    robHeadState = v.st;
    robHeadDest  = v.dest;
    robHeadType  = v.typ;
    commitEn     = v.en;
    stAck        = v.ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    checkOutput({tag, " commit_head"}, 32'(commitHead), 32'(v.eCh));
    checkOutput({tag, " rf_valid"}, 32'(rfCommitValid), 32'(v.eRv));
    if (v.eRv) begin
      checkOutput({tag, " rf_addr"}, 32'(rfCommitAddr), 32'(v.eRa));
      checkOutput({tag, " rf_rob_id"}, 32'(rfCommitRobId), 32'(v.eRid));
    end
    checkOutput({tag, " st_req"}, 32'(stReq), 32'(v.eSr));
    if (v.eSr) begin
      checkOutput({tag, " st_rob_id"}, 32'(stRobId), 32'(v.eSid));
    end
    checkOutput({tag, " halted"}, 32'(halted), 32'(v.eHl));
    checkOutput({tag, " retired_count"}, retiredCount, 32'(v.eCnt));
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    // rst head tail full st dest type en ack | ch rv ra rid sr sid hl cnt
    vecs.push_back('{1'b1, 5'd3, 5'd3, 1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd5, 5'd9, 1'b0, 1'b1, 4'hA, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 5'd5, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd6, 5'd9, 1'b0, 1'b1, 4'h2, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1});
    vecs.push_back('{1'b0, 5'd7, 5'd9, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd7, 5'd9, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b1, 5'd7, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd7, 5'd9, 1'b0, 1'b1, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b1, 5'd7, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd7, 5'd9, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b1, 5'd7, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd7, 5'd9, 1'b0, 1'b1, 4'h0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 5'd0, 1'b1, 5'd7, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd8, 5'd9, 1'b0, 1'b1, 4'h3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 3});
    vecs.push_back('{1'b0, 5'd8, 5'd9, 1'b0, 1'b1, 4'h3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 5'd8, 1'b0, 5'd0, 1'b0, 3});
    vecs.push_back('{1'b0, 5'd9, 5'd12, 1'b0, 1'b0, 4'h4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4});
    vecs.push_back('{1'b0, 5'd9, 5'd12, 1'b0, 1'b1, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4});
    vecs.push_back('{1'b0, 5'd9, 5'd12, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4});
    vecs.push_back('{1'b1, 5'd9, 5'd12, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 4});
    vecs.push_back('{1'b0, 5'd9, 5'd12, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd9, 5'd12, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 5'd0, 1'b1, 5'd9, 1'b0, 0});
    vecs.push_back('{1'b0, 5'd10, 5'd12, 1'b0, 1'b1, 4'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1});
    vecs.push_back('{1'b0, 5'd11, 5'd12, 1'b0, 1'b1, 4'h5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b1, 2});
    vecs.push_back('{1'b0, 5'd11, 5'd12, 1'b0, 1'b1, 4'h5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b1, 2});
    vecs.push_back('{1'b1, 5'd11, 5'd12, 1'b0, 1'b1, 4'h5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 2});
    vecs.push_back('{1'b0, 5'd11, 5'd11, 1'b0, 1'b1, 4'h5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 0});

    v = vecs[0];
    applyStimulus(v);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVec(i, vecs[i]);
      @(negedge clk);
    end

    // Full ROB (head == tail, full set) retiring 32 ALU ops back to back.
    for (int i = 0; i < 32; i++) begin
      v = '{1'b0, 5'(i), 5'd0, (i == 0), 1'b1, 4'(i), 2'b00, 1'b1, 1'b0,
            1'b1, 1'b1, 4'(i), 5'(i), 1'b0, 5'd0, 1'b0, i};
      applyStimulus(v);
      #1;
      checkVec(100 + i, v);
      @(negedge clk);
    end
    v = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 1'b0,
          1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 1'b0, 32};
    applyStimulus(v);
    #1;
    checkVec(200, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
